// File: rtl/sbox_dec_layer_ctrl.sv
// BORON decryption inverse-substitution sequencer: streams the 16 nibbles of a
// 64-bit state through LANES external inverse S-boxes, LANES nibbles per cycle.
module sbox_dec_layer_ctrl #(
    parameter int unsigned LANES = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [63:0]        data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [63:0]        data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [4*LANES-1:0] sbox_di_o,
    input  logic [4*LANES-1:0] sbox_do_i,
    output logic               busy_o
);

    localparam int unsigned STEPS = 16 / LANES;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned W     = 4 * LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   step_q, step_d;
    logic [63:0]     data_q, data_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            step_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        data_d    = data_q;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        busy_o    = 1'b0;
        sbox_di_o = '0;

        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    data_d  = data_i;
                    step_d  = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                busy_o = 1'b1;
                // Constant-index slice per step keeps the lane mux free of
                // variable part-selects; only the matching step is active.
                for (int unsigned k = 0; k < STEPS; k++) begin
                    if (step_q == CW'(k)) begin
                        sbox_di_o           = data_q[k*W +: W];
                        data_d[k*W +: W]    = sbox_do_i;
                    end
                end
                if (step_q == CW'(STEPS - 1)) begin
                    step_d  = '0;
                    state_d = DONE;
                end else begin
                    step_d  = step_q + CW'(1);
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    assign data_o = data_q;

endmodule

// File: tb/tb_sbox_dec_layer_ctrl.sv
// Directed bench for sbox_dec_layer_ctrl: one instance per legal LANES value,
// each served by a behavioural inverse S-box bank.
module tb_sbox_dec_layer_ctrl;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [63:0] din   [5];
    logic [63:0] dout  [5];
    logic [63:0] sdi   [5];
    logic [63:0] sdo   [5];
    logic        vin   [5];
    logic        rin   [5];
    logic        rdy_o [5];
    logic        vout  [5];
    logic        busy  [5];

    logic [3:0]  sdi_l1,  sdo_l1;
    logic [7:0]  sdi_l2,  sdo_l2;
    logic [15:0] sdi_l4,  sdo_l4;
    logic [31:0] sdi_l8,  sdo_l8;
    logic [63:0] sdi_l16, sdo_l16;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hA;  4'h1: return 4'h3;  4'h2: return 4'h9;  4'h3: return 4'hE;
            4'h4: return 4'h1;  4'h5: return 4'hD;  4'h6: return 4'hF;  4'h7: return 4'h4;
            4'h8: return 4'hC;  4'h9: return 4'h5;  4'hA: return 4'h7;  4'hB: return 4'h2;
            4'hC: return 4'h6;  4'hD: return 4'h8;  4'hE: return 4'h0;  default: return 4'hB;
        endcase
    endfunction

    function automatic logic [63:0] inv_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        return r;
    endfunction

    always_comb begin
        sdi[0] = 64'(sdi_l1);
        sdi[1] = 64'(sdi_l2);
        sdi[2] = 64'(sdi_l4);
        sdi[3] = 64'(sdi_l8);
        sdi[4] = sdi_l16;
        for (int i = 0; i < 5; i++) sdo[i] = inv_layer(sdi[i]);
        sdo_l1  = sdo[0][3:0];
        sdo_l2  = sdo[1][7:0];
        sdo_l4  = sdo[2][15:0];
        sdo_l8  = sdo[3][31:0];
        sdo_l16 = sdo[4];
    end

    sbox_dec_layer_ctrl #(.LANES(1)) u_l1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(din[0]), .valid_i(vin[0]), .ready_o(rdy_o[0]),
        .data_o(dout[0]), .valid_o(vout[0]), .ready_i(rin[0]), .sbox_di_o(sdi_l1),
        .sbox_do_i(sdo_l1), .busy_o(busy[0]));
    sbox_dec_layer_ctrl #(.LANES(2)) u_l2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(din[1]), .valid_i(vin[1]), .ready_o(rdy_o[1]),
        .data_o(dout[1]), .valid_o(vout[1]), .ready_i(rin[1]), .sbox_di_o(sdi_l2),
        .sbox_do_i(sdo_l2), .busy_o(busy[1]));
    sbox_dec_layer_ctrl #(.LANES(4)) u_l4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(din[2]), .valid_i(vin[2]), .ready_o(rdy_o[2]),
        .data_o(dout[2]), .valid_o(vout[2]), .ready_i(rin[2]), .sbox_di_o(sdi_l4),
        .sbox_do_i(sdo_l4), .busy_o(busy[2]));
    sbox_dec_layer_ctrl #(.LANES(8)) u_l8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(din[3]), .valid_i(vin[3]), .ready_o(rdy_o[3]),
        .data_o(dout[3]), .valid_o(vout[3]), .ready_i(rin[3]), .sbox_di_o(sdi_l8),
        .sbox_do_i(sdo_l8), .busy_o(busy[3]));
    sbox_dec_layer_ctrl #(.LANES(16)) u_l16 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(din[4]), .valid_i(vin[4]), .ready_o(rdy_o[4]),
        .data_o(dout[4]), .valid_o(vout[4]), .ready_i(rin[4]), .sbox_di_o(sdi_l16),
        .sbox_do_i(sdo_l16), .busy_o(busy[4]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int idx);
        check("rst_ready", 64'(rdy_o[idx]), 64'd1);
        check("rst_valid", 64'(vout[idx]), 64'd0);
        check("rst_busy",  64'(busy[idx]), 64'd0);
        check("rst_data",  dout[idx], 64'd0);
        check("rst_sbox_di", sdi[idx], 64'd0);
    endtask

    // Called on a falling edge with the instance idle; returns on the falling
    // edge where valid_o was first seen (plus one cycle if rel is set).
    task automatic run_block(input int idx, input logic [63:0] d, input logic [63:0] exp, input bit rel);
        int lanes, steps, e, nb;
        logic [63:0] mask, want;
        lanes = 1 << idx;
        steps = 16 >> idx;
        mask  = (lanes == 16) ? '1 : ((64'd1 << (4 * lanes)) - 64'd1);
        rin[idx] = rel;
        din[idx] = d;
        vin[idx] = 1'b1;
        check("accept_ready", 64'(rdy_o[idx]), 64'd1);
        @(negedge clk_i);
        vin[idx] = 1'b0;
        e  = 1;
        nb = 0;
        while (!vout[idx] && e < 40) begin
            check("busy_in_sub", 64'(busy[idx]), 64'd1);
            want = (nb < steps) ? ((d >> (4 * lanes * nb)) & mask) : 64'd0;
            check("lane_order", sdi[idx], want);
            nb++;
            @(negedge clk_i);
            e++;
        end
        check("latency", 64'(e), 64'(steps + 1));
        check("busy_cycles", 64'(nb), 64'(steps));
        check("done_busy", 64'(busy[idx]), 64'd0);
        check("done_ready", 64'(rdy_o[idx]), 64'd0);
        check("done_sbox_di", sdi[idx], 64'd0);
        check("data_o", dout[idx], exp);
        if (rel) begin
            @(negedge clk_i);
            check("idle_ready", 64'(rdy_o[idx]), 64'd1);
            check("idle_valid", 64'(vout[idx]), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            din[i] = '0;
            vin[i] = 1'b0;
            rin[i] = 1'b1;
        end

        // Reset state
        #12;
        check_reset_outputs(0);
        check_reset_outputs(2);
        check_reset_outputs(4);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single block, LANES=1
        run_block(0, 64'h0123456789ABCDEF, 64'hA39E1DF4C572680B, 1'b1);

        // Constant inputs, LANES=4
        run_block(2, 64'h0000000000000000, 64'hAAAAAAAAAAAAAAAA, 1'b1);
        run_block(2, 64'hFFFFFFFFFFFFFFFF, 64'hBBBBBBBBBBBBBBBB, 1'b1);

        // Back-pressure, LANES=4
        run_block(2, 64'h0123456789ABCDEF, 64'hA39E1DF4C572680B, 1'b0);
        for (int c = 0; c < 10; c++) begin
            din[2] = 64'h5555AAAA5555AAAA;
            vin[2] = 1'b1;
            @(negedge clk_i);
            check("bp_data", dout[2], 64'hA39E1DF4C572680B);
            check("bp_valid", 64'(vout[2]), 64'd1);
            check("bp_ready", 64'(rdy_o[2]), 64'd0);
        end
        vin[2] = 1'b0;
        rin[2] = 1'b1;
        @(negedge clk_i);
        check("bp_release_ready", 64'(rdy_o[2]), 64'd1);
        check("bp_release_valid", 64'(vout[2]), 64'd0);
        check("bp_release_data", dout[2], 64'hA39E1DF4C572680B);
        run_block(2, 64'hFEDCBA9876543210, 64'hB086275C4FD1E93A, 1'b1);

        // Reset mid-SUB, LANES=1
        din[0] = 64'h0123456789ABCDEF;
        vin[0] = 1'b1;
        @(negedge clk_i);
        vin[0] = 1'b0;
        repeat (7) @(negedge clk_i);
        check("mid_step7_sbox_di", sdi[0], 64'h8);
        check("mid_busy", 64'(busy[0]), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        check_reset_outputs(0);
        repeat (2) begin
            @(negedge clk_i);
            check("mid_no_valid", 64'(vout[0]), 64'd0);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_valid", 64'(vout[0]), 64'd0);
        run_block(0, 64'hFEDCBA9876543210, 64'hB086275C4FD1E93A, 1'b1);

        // Random sweep over LANES 1, 2, 8, 16
        for (int s = 0; s < 4; s++) begin
            int idx;
            logic [63:0] r;
            idx = (s < 2) ? s : s + 1;
            for (int b = 0; b < 1000; b++) begin
                r = {$urandom, $urandom};
                run_block(idx, r, inv_layer(r), 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
